// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   - request opcodes (MUH_*) carried on req_op
//   - sequencer state encoding
//   - small helpers that classify opcodes
package muldiv_pkg;

  typedef logic [2:0] muh_op_t;

  localparam muh_op_t MUH_MULT  = 3'd0;
  localparam muh_op_t MUH_MULTU = 3'd1;
  localparam muh_op_t MUH_DIV   = 3'd2;
  localparam muh_op_t MUH_DIVU  = 3'd3;
  localparam muh_op_t MUH_MTHI  = 3'd4;
  localparam muh_op_t MUH_MTLO  = 3'd5;

  // LO value produced by a divide by zero; HI receives the dividend
  localparam logic [31:0] DZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_SEND,
    DIV_WAIT,
    DZERO,
    DRAIN
  } muh_state_e;

  function automatic logic is_mul_op(input muh_op_t op);
    return (op == MUH_MULT) || (op == MUH_MULTU);
  endfunction

  function automatic logic is_div_op(input muh_op_t op);
    return (op == MUH_DIV) || (op == MUH_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if
//   Request handshake between the EX stage and the HI/LO sequencer.
//   req_valid  EX stage presents a request
//   req_ready  sequencer accepts on this edge when req_valid & req_ready
//   req_op     MUH_* opcode
//   req_src1   rs: dividend / multiplicand / MTHI,MTLO data
//   req_src2   rt: divisor / multiplier
//   master = EX stage side, slave = sequencer side.
interface muldiv_hilo_ctrl_if;
  import muldiv_pkg::*;

  logic        req_valid;
  logic        req_ready;
  muh_op_t     req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;

  modport master (
    output req_valid,
    output req_op,
    output req_src1,
    output req_src2,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_src1,
    input  req_src2,
    output req_ready
  );

endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Sequencer for the multi-cycle multiply/divide resources behind EX.
//   Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time, owns the
//   architectural HI/LO registers, drives the external divider over its
//   stream handshake, counts multiplier latency, and cancels or drains
//   in-flight work on a pipeline flush.
// Ports
//   clk, resetn          clock (rising edge), async active-low reset
//   req                  request handshake (slave modport)
//   flush                pipeline flush, cancels the held request
//   mul_a/mul_b/mul_signed   multiplier operands, registered at accept
//   mul_prod             product, valid MUL_LAT cycles after accept
//   div_dividend/div_divisor/div_signed/div_tvalid/div_tready  divider input stream
//   div_dout/div_dout_tvalid   divider result {quotient, remainder}
//   hi, lo               architectural HI/LO
//   busy                 sequencer not idle (pipeline stall)
//   done                 one-cycle pulse once a MUL/DIV result lands in HI/LO
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  muldiv_hilo_ctrl_if.slave   req,
  input  logic                flush,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  output logic                mul_signed,
  input  logic [63:0]         mul_prod,
  output logic [31:0]         div_dividend,
  output logic [31:0]         div_divisor,
  output logic                div_signed,
  output logic                div_tvalid,
  input  logic                div_tready,
  input  logic [63:0]         div_dout,
  input  logic                div_dout_tvalid,
  output logic [31:0]         hi,
  output logic [31:0]         lo,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  muh_state_e  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] dz_src;
  logic        done_nx;
  logic        accept;

  assign req.req_ready = (state == IDLE) & ~flush;
  assign accept        = req.req_valid & req.req_ready;
  assign busy          = (state != IDLE);
  assign div_tvalid    = (state == DIV_SEND);

  // State, latency counter and the architectural HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      done  <= done_nx;
    end
  end

  // Next-state and HI/LO update; flush always wins over a same-cycle completion
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (req.req_op)
            MUH_MTHI:            hi_nx = req.req_src1;
            MUH_MTLO:            lo_nx = req.req_src1;
            MUH_MULT, MUH_MULTU: begin
              state_nx = MUL;
              cnt_nx   = CNT_INIT;
            end
            MUH_DIV, MUH_DIVU:   state_nx = (req.req_src2 == '0) ? DZERO : DIV_SEND;
            default:             ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          {hi_nx, lo_nx} = mul_prod;
          done_nx        = 1'b1;
          state_nx       = IDLE;
        end
      end
      DIV_SEND: begin
        // Once tready is seen the divider owns the operands, so a flush must drain
        if (flush) begin
          state_nx = div_tready ? DRAIN : IDLE;
        end else if (div_tready) begin
          state_nx = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        if (flush) begin
          state_nx = div_dout_tvalid ? IDLE : DRAIN;
        end else if (div_dout_tvalid) begin
          lo_nx    = div_dout[63:32];
          hi_nx    = div_dout[31:0];
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      DZERO: begin
        if (flush) begin
          state_nx = IDLE;
        end else begin
          hi_nx    = dz_src;
          lo_nx    = DZERO_LO;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (div_dout_tvalid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at accept; a zero divisor never reaches the divider
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a        <= '0;
      mul_b        <= '0;
      mul_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_signed   <= 1'b0;
      dz_src       <= '0;
    end else if (accept) begin
      if (is_mul_op(req.req_op)) begin
        mul_a      <= req.req_src1;
        mul_b      <= req.req_src2;
        mul_signed <= (req.req_op == MUH_MULT);
      end
      if (is_div_op(req.req_op)) begin
        if (req.req_src2 != '0) begin
          div_dividend <= req.req_src1;
          div_divisor  <= req.req_src2;
          div_signed   <= (req.req_op == MUH_DIV);
        end else begin
          dz_src <= req.req_src1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
//   Scoreboard bench for muldiv_hilo_ctrl. Requests are issued from the
//   main process; each MUL/DIV expected to complete pushes its HI/LO into
//   a queue that a separate monitor pops on every done pulse. Multiplier
//   and divider IP are modelled behaviourally with randomised latencies.
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int TIMEOUT = 300;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic        flush  = 1'b0;
  logic [31:0] mul_a, mul_b, div_dividend, div_divisor, hi, lo;
  logic        mul_signed, div_signed, div_tvalid, busy, done;
  logic [63:0] mul_prod;
  logic        div_tready      = 1'b0;
  logic [63:0] div_dout        = '0;
  logic        div_dout_tvalid = 1'b0;

  muldiv_hilo_ctrl_if req_if ();

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req             (req_if),
    .flush           (flush),
    .mul_a           (mul_a),
    .mul_b           (mul_b),
    .mul_signed      (mul_signed),
    .mul_prod        (mul_prod),
    .div_dividend    (div_dividend),
    .div_divisor     (div_divisor),
    .div_signed      (div_signed),
    .div_tvalid      (div_tvalid),
    .div_tready      (div_tready),
    .div_dout        (div_dout),
    .div_dout_tvalid (div_dout_tvalid),
    .hi              (hi),
    .lo              (lo),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int          ready_delay_cfg = 0;
  int          ip_lat_cfg      = 0;

  // Plain-arithmetic reference for the multiplier
  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Divider result as {quotient, remainder}, truncating toward zero
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = a;
      sb = b;
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Multiplier IP: product is only correct exactly MUL_LAT edges after accept
  int mul_age = 100;
  always @(posedge clk) begin
    if (req_if.req_valid && req_if.req_ready &&
        (req_if.req_op == MUH_MULT || req_if.req_op == MUH_MULTU))
      mul_age <= 0;
    else if (mul_age < 100)
      mul_age <= mul_age + 1;
  end
  assign mul_prod = (mul_age == MUL_LAT - 1) ? ref_mul(mul_signed, mul_a, mul_b)
                                             : 64'hDEAD_BEEF_0BAD_F00D;

  // Divider IP: tready after a configurable delay, result after a configurable latency
  initial begin : div_ip
    bit          ip_pending;
    int          ip_left;
    int          tvalid_age;
    logic [63:0] ip_result;
    ip_pending = 0;
    ip_left    = 0;
    tvalid_age = 0;
    ip_result  = '0;
    forever begin
      @(negedge clk);
      div_dout_tvalid = 1'b0;
      if (!resetn) begin
        ip_pending = 0;
        tvalid_age = 0;
        div_tready = 1'b0;
      end else begin
        if (ip_pending) begin
          if (ip_left == 0) begin
            div_dout_tvalid = 1'b1;
            div_dout        = ip_result;
            ip_pending      = 0;
          end else begin
            ip_left--;
          end
        end
        if (div_tvalid && !ip_pending) begin
          div_tready = (tvalid_age >= ready_delay_cfg);
          tvalid_age++;
        end else begin
          div_tready = 1'b0;
          tvalid_age = 0;
        end
        if (div_tvalid && div_tready) begin
          ip_result  = ref_div(div_signed, div_dividend, div_divisor);
          ip_pending = 1;
          ip_left    = ip_lat_cfg;
          tvalid_age = 0;
        end
      end
    end
  end

  // Monitor: every done pulse must match the oldest expected result
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && done) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
          checkOutput({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  // One-cycle request starting at a negedge; returns at the negedge after the accept edge
  task automatic issue(input muh_op_t op, input logic [31:0] s1, input logic [31:0] s2);
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.req_src1  = s1;
    req_if.req_src2  = s2;
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    req_if.req_src1  = $urandom;
    req_if.req_src2  = $urandom;
  endtask

  task automatic applyStimulus(input muh_op_t op, input logic [31:0] s1, input logic [31:0] s2,
                               input bit do_flush);
    logic [63:0] r;
    string nm;
    waitIdle();
    checkOutput("idle_hilo", {hi, lo}, {model_hi, model_lo});
    nm = "";
    case (op)
      MUH_MTHI: model_hi = s1;
      MUH_MTLO: model_lo = s1;
      MUH_MULT, MUH_MULTU: begin
        r  = ref_mul(op == MUH_MULT, s1, s2);
        nm = (op == MUH_MULT) ? "mult" : "multu";
        if (!do_flush) begin
          model_hi = r[63:32];
          model_lo = r[31:0];
        end
      end
      MUH_DIV, MUH_DIVU: begin
        nm = (s2 == '0) ? "dzero" : ((op == MUH_DIV) ? "div" : "divu");
        if (!do_flush) begin
          if (s2 == '0) begin
            model_hi = s1;
            model_lo = 32'hFFFF_FFFF;
          end else begin
            r        = ref_div(op == MUH_DIV, s1, s2);
            model_lo = r[63:32];
            model_hi = r[31:0];
          end
        end
      end
      default: ;
    endcase
    if (nm != "" && !do_flush) sb_q.push_back('{hi: model_hi, lo: model_lo, name: nm});
    issue(op, s1, s2);
    if (op == MUH_MTHI || op == MUH_MTLO) begin
      checkOutput("mt_hilo", {hi, lo}, {model_hi, model_lo});
      checkOutput("mt_busy", 64'(busy), 64'd0);
    end
    if (do_flush) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  initial begin : main
    int          lat;
    int          bad_ready;
    int          n;
    muh_op_t     op;
    logic [31:0] s1, s2;

    req_if.req_valid = 1'b0;
    req_if.req_op    = MUH_MTHI;
    req_if.req_src1  = '0;
    req_if.req_src2  = '0;

    // Reset values
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_req_ready", 64'(req_if.req_ready), 64'd1);
    checkOutput("reset_div_tvalid", 64'(div_tvalid), 64'd0);
    checkOutput("reset_mul_a", {32'b0, mul_a}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // MTHI / MTLO
    applyStimulus(MUH_MTHI, 32'h0000_1234, 32'h0, 1'b0);
    applyStimulus(MUH_MTLO, 32'h0000_5678, 32'h0, 1'b0);
    checkOutput("t1_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // MULT latency and signed product
    applyStimulus(MUH_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    lat = -1;
    for (int k = 0; k < MUL_LAT + 4; k++) begin
      if (done && lat < 0) lat = k;
      @(negedge clk);
    end
    checkOutput("t2_mult_done_cycle", 64'(lat), 64'(MUL_LAT));
    checkOutput("t2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // DIVU with slow tready and long IP latency
    ready_delay_cfg = 3;
    ip_lat_cfg      = 36;
    applyStimulus(MUH_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    checkOutput("t3_tvalid_held", 64'(div_tvalid), 64'd1);
    checkOutput("t3_div_operands", {div_dividend, div_divisor}, {32'd100, 32'd7});
    checkOutput("t3_div_signed", 64'(div_signed), 64'd0);
    waitIdle();
    checkOutput("t3_hilo", {hi, lo}, {32'd2, 32'd14});
    checkOutput("t3_tvalid_idle", 64'(div_tvalid), 64'd0);

    // Divide by zero bypasses the divider
    ready_delay_cfg = 0;
    ip_lat_cfg      = 3;
    applyStimulus(MUH_DIV, 32'd5, 32'd0, 1'b0);
    checkOutput("t4_tvalid", 64'(div_tvalid), 64'd0);
    checkOutput("t4_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("t4_done", 64'(done), 64'd1);
    checkOutput("t4_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // Flush in DIV_WAIT drains the divider and discards its result
    ip_lat_cfg = 10;
    waitIdle();
    issue(MUH_DIV, 32'd100, 32'd7);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t5_busy_drain", 64'(busy), 64'd1);
    bad_ready = 0;
    n = 0;
    while (busy && n < TIMEOUT) begin
      if (req_if.req_ready) bad_ready++;
      @(negedge clk);
      n++;
    end
    checkOutput("t5_ready_in_drain", 64'(bad_ready), 64'd0);
    checkOutput("t5_drain_ends", 64'(busy), 64'd0);
    checkOutput("t5_hilo_unchanged", {hi, lo}, {model_hi, model_lo});

    // Request with flush in the same cycle is not accepted
    req_if.req_valid = 1'b1;
    req_if.req_op    = MUH_MTHI;
    req_if.req_src1  = 32'h0000_0BAD;
    flush            = 1'b1;
    #1;
    checkOutput("t6_ready_masked", 64'(req_if.req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    flush            = 1'b0;
    checkOutput("t6_not_accepted", {hi, lo}, {model_hi, model_lo});
    checkOutput("t6_busy", 64'(busy), 64'd0);

    // Reset in the middle of a multiply
    issue(MUH_MULT, 32'd7, 32'd9);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("t6_reset_hilo", {hi, lo}, 64'd0);
    checkOutput("t6_reset_busy", 64'(busy), 64'd0);
    checkOutput("t6_reset_done", 64'(done), 64'd0);
    model_hi = '0;
    model_lo = '0;
    resetn   = 1'b1;
    @(negedge clk);

    // Randomised mix with occasional flush right after accept
    for (int i = 0; i < 60; i++) begin
      ready_delay_cfg = $urandom_range(0, 3);
      ip_lat_cfg      = $urandom_range(0, 5);
      op = muh_op_t'($urandom_range(0, 5));
      s1 = $urandom;
      if ($urandom_range(0, 7) == 0) s2 = 32'd0;
      else if ($urandom_range(0, 1) == 1) s2 = $urandom;
      else s2 = $urandom_range(1, 50);
      if ($urandom_range(0, 3) == 0) s1 = $urandom_range(0, 1000);
      if (op == MUH_DIV && s1 == 32'h8000_0000 && s2 == 32'hFFFF_FFFF) s2 = 32'd3;
      applyStimulus(op, s1, s2, $urandom_range(0, 5) == 0);
    end

    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
    checkOutput("final_hilo", {hi, lo}, {model_hi, model_lo});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
